// File: rtl/divisor_sequencial.sv
// Multi-cycle restoring divider for the 8-bit calculator datapath.
// One quotient bit per clock; divide-by-zero is flagged in a single extra cycle.
module divisor_sequencial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             resto_existe,
  output logic             erro
);

  // state | meaning
  // IDLE  | waiting for start; results from the last operation are held
  // CALC  | one restoring step per clock, counter runs WIDTH down to 0
  // ZERO  | divisor was zero; report error on the next edge

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra top bit.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dsr_q});
  assign rem_next = ge ? WIDTH'(shifted - {1'b0, dsr_q}) : shifted[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rem_q        <= '0;
      dvd_q        <= '0;
      dsr_q        <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quociente    <= '0;
      resto        <= '0;
      resto_existe <= 1'b0;
      erro         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= A;
            dsr_q <= B;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= (B == '0) ? ZERO : CALC;
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            quociente    <= quo_next;
            resto        <= rem_next;
            erro         <= 1'b0;
            resto_existe <= (rem_next != '0);
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        ZERO: begin
          quociente    <= '0;
          resto        <= dvd_q;
          erro         <= 1'b1;
          resto_existe <= 1'b0;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed vector table,
// hand-written corner sequences and a reduced sweep against a reference model.
module tb_divisor_sequencial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       resto_existe;
  logic       erro;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  divisor_sequencial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .quociente(quociente), .resto(resto),
    .resto_existe(resto_existe), .erro(erro)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       re;
    logic       er;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done; lat counts edges after E0.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat, output logic busy_e0);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_e0 = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int         lat;
    logic       be0;
    logic [7:0] eq, er_;
    logic       ere, eer;
    int         elat;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b1, 1'b0, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8};
    vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b1, 1'b0, 8};
    vecs[3] = '{8'd5,   8'd0,   8'd0,   8'd5,   1'b0, 1'b1, 1};
    vecs[4] = '{8'd6,   8'd3,   8'd2,   8'd0,   1'b0, 1'b0, 8};
    vecs[5] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 8};
    vecs[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b1, 1'b0, 8};
    vecs[8] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 1'b0, 8};
    vecs[9] = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b1, 1'b0, 8};

    rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, quociente, resto, resto_existe, erro}, 20'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, be0);
      exp_done++;
      chk($sformatf("v%0d_busy_e0", i), be0, 1'b1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quociente", i), quociente, vecs[i].q);
      chk($sformatf("v%0d_resto", i), resto, vecs[i].r);
      chk($sformatf("v%0d_resto_existe", i), resto_existe, vecs[i].re);
      chk($sformatf("v%0d_erro", i), erro, vecs[i].er);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
      chk($sformatf("v%0d_hold_q", i), quociente, vecs[i].q);
    end

    // start and operand changes while busy are ignored
    A = 8'd200; B = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_mid_op", busy, 1'b1);
    chk("hold_q_while_busy", quociente, 8'd127);
    A = 8'd1; B = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    exp_done++;
    chk("ign_latency", lat, 8);
    chk("ign_quociente", quociente, 8'd22);
    chk("ign_resto", resto, 8'd2);
    repeat (3) begin @(posedge clk); #1; end
    chk("ign_no_restart", busy, 1'b0);

    // asynchronous reset mid-operation aborts without done
    A = 8'd50; B = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, quociente, resto, resto_existe, erro}, 20'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, exp_done);
    do_op(8'd50, 8'd4, lat, be0);
    exp_done++;
    chk("after_abort_latency", lat, 8);
    chk("after_abort_q", quociente, 8'd12);
    chk("after_abort_r", resto, 8'd2);

    // reduced sweep with back-to-back starts against a reference model
    for (int n = 0; n < 700; n++) begin
      logic [7:0] a, b;
      if (n < 360) begin
        a = 8'((n % 20) * 13);
        b = 8'((n / 20) * 15);
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      if (n >= 360 && n < 400) b = 8'(n % 3);
      if (b == 8'd0) begin
        eq = 8'd0; er_ = a; ere = 1'b0; eer = 1'b1; elat = 1;
      end else begin
        eq = a / b; er_ = a % b; ere = (er_ != 8'd0); eer = 1'b0; elat = 8;
      end
      do_op(a, b, lat, be0);
      exp_done++;
      chk($sformatf("sweep_a%0d_b%0d", a, b),
          {quociente, resto, resto_existe, erro, 8'(lat)},
          {eq, er_, ere, eer, 8'(elat)});
    end

    @(posedge clk); #1;
    chk("done_count", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
